// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 16-bit add/sub datapath among N_REQ requesters.
// Define ADDER_ARB_SAT_EN to clamp overflowed results to 0x7FFF / 0x8000.
module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   a_bus,
    input  logic [16*N_REQ-1:0]   b_bus,
    input  logic [N_REQ-1:0]      sub_vec,
    output logic [N_REQ-1:0]      gnt,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [15:0]           res_sum,
    output logic [TAG_W-1:0]      res_tag,
    output logic                  res_ovf,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic             sub_q, sub_d;
    logic [TAG_W-1:0] idx_q, idx_d;

    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [15:0]      sum_q, sum_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             ovf_q, ovf_d;

    logic             found;
    logic [TAG_W-1:0] sel_idx;
    logic [15:0]      a_sel;
    logic [15:0]      b_sel;
    logic             sub_sel;

    logic [16:0]      a_x;
    logic [16:0]      b_x;
    logic [16:0]      exact;
    logic             calc_ovf;
    logic [15:0]      calc_sum;

    // Cyclic search for the first requester at or after rr_ptr.
    always_comb begin : sel_search
        int               j;
        logic [TAG_W-1:0] cand;
        found   = 1'b0;
        sel_idx = '0;
        j       = 0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = TAG_W'(j);
            if (!found && req[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Operand mux for the selected requester (constant slices only).
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel_idx == TAG_W'(k)) begin
                a_sel   = a_bus[16*k +: 16];
                b_sel   = b_bus[16*k +: 16];
                sub_sel = sub_vec[k];
            end
        end
    end

    // Exact 17-bit signed add/sub; overflow when it leaves 16-bit range.
    always_comb begin
        a_x      = {a_q[15], a_q};
        b_x      = {b_q[15], b_q};
        exact    = sub_q ? (a_x - b_x) : (a_x + b_x);
        calc_ovf = exact[16] ^ exact[15];
`ifdef ADDER_ARB_SAT_EN
        if (calc_ovf) begin
            calc_sum = exact[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            calc_sum = exact[15:0];
        end
`else
        calc_sum = exact[15:0];
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output / datapath next values per state.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        idx_d    = idx_q;
        gnt_d    = '0;
        valid_d  = valid_q;
        sum_d    = sum_q;
        tag_d    = tag_q;
        ovf_d    = ovf_q;
        busy     = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    a_d            = a_sel;
                    b_d            = b_sel;
                    sub_d          = sub_sel;
                    idx_d          = sel_idx;
                    gnt_d[sel_idx] = 1'b1;
                end
            end
            EXEC: begin
                sum_d   = calc_sum;
                ovf_d   = calc_ovf;
                tag_d   = idx_q;
                valid_d = 1'b1;
            end
            RESP: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    if (tag_q == TAG_W'(N_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = tag_q + 1'b1;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            idx_q    <= '0;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            sum_q    <= '0;
            tag_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            idx_q    <= idx_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            sum_q    <= sum_d;
            tag_q    <= tag_d;
            ovf_q    <= ovf_d;
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = valid_q;
    assign res_sum   = sum_q;
    assign res_tag   = tag_q;
    assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized and directed bench for adder_arbiter against a
// transaction-level reference model.
module tb_adder_arbiter;

    localparam int N  = 4;
    localparam int TW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [16*N-1:0]   a_bus;
    logic [16*N-1:0]   b_bus;
    logic [N-1:0]      sub_vec;
    logic [N-1:0]      gnt;
    logic              res_valid;
    logic              res_ready;
    logic [15:0]       res_sum;
    logic [TW-1:0]     res_tag;
    logic              res_ovf;
    logic              busy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    adder_arbiter #(.N_REQ(N), .TAG_W(TW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .a_bus(a_bus),
        .b_bus(b_bus),
        .sub_vec(sub_vec),
        .gnt(gnt),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_sum(res_sum),
        .res_tag(res_tag),
        .res_ovf(res_ovf),
        .busy(busy)
    );

    task automatic cmp(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Arithmetic reference computed with plain integers.
    task automatic ref_op(input logic [15:0] a, input logic [15:0] b,
                          input bit s, output logic [15:0] sum,
                          output bit ovf);
        int ea;
        int eb;
        int ex;
        ea  = $signed(a);
        eb  = $signed(b);
        ex  = s ? (ea - eb) : (ea + eb);
        ovf = (ex > 32767) || (ex < -32768);
        sum = ex[15:0];
`ifdef ADDER_ARB_SAT_EN
        if (ovf) sum = (ex > 0) ? 16'h7FFF : 16'h8000;
`endif
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Reference model: phase 0 waiting, 1 granted, 2 result held.
    int           m_phase = 0;
    int           m_ptr   = 0;
    int           m_idx   = 0;
    logic [15:0]  m_a     = '0;
    logic [15:0]  m_b     = '0;
    bit           m_sub   = 1'b0;
    logic [N-1:0] e_gnt   = '0;
    bit           e_valid = 1'b0;
    logic [15:0]  e_sum   = '0;
    int           e_tag   = 0;
    bit           e_ovf   = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_ptr   = 0;
            e_gnt   = '0;
            e_valid = 1'b0;
            e_sum   = '0;
            e_tag   = 0;
            e_ovf   = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    e_gnt = '0;
                    if (req != '0) begin
                        m_idx        = pick(req, m_ptr);
                        m_a          = a_bus[16*m_idx +: 16];
                        m_b          = b_bus[16*m_idx +: 16];
                        m_sub        = sub_vec[m_idx];
                        e_gnt[m_idx] = 1'b1;
                        m_phase      = 1;
                    end
                end
                1: begin
                    e_gnt = '0;
                    ref_op(m_a, m_b, m_sub, e_sum, e_ovf);
                    e_tag   = m_idx;
                    e_valid = 1'b1;
                    m_phase = 2;
                end
                default: begin
                    if (res_ready) begin
                        e_valid = 1'b0;
                        m_ptr   = (e_tag + 1) % N;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m_gnt", 32'(gnt), 32'(e_gnt));
            cmp("m_valid", 32'(res_valid), 32'(e_valid));
            cmp("m_sum", 32'(res_sum), 32'(e_sum));
            cmp("m_tag", 32'(res_tag), e_tag);
            cmp("m_ovf", 32'(res_ovf), 32'(e_ovf));
            cmp("m_busy", 32'(busy), 32'(m_phase != 0));
        end
    end

    task automatic set_op(input int i, input logic [15:0] a,
                          input logic [15:0] b, input bit s);
        a_bus[16*i +: 16] = a;
        b_bus[16*i +: 16] = b;
        sub_vec[i]        = s;
    endtask

    function automatic logic [15:0] rnd16();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 6)
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'hFFFF;
            4: return 16'h0001;
            default: return r[15:0];
        endcase
    endfunction

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            set_op(i, rnd16(), rnd16(), bit'($urandom % 2));
        end
    endtask

    task automatic do_op(input int i, input logic [15:0] a,
                         input logic [15:0] b, input bit s,
                         input logic [15:0] xs, input bit xo);
        set_op(i, a, b, s);
        req       = N'(1 << i);
        res_ready = 1'b1;
        @(negedge clk);
        cmp("op_gnt", 32'(gnt), 32'(1 << i));
        cmp("op_busy", 32'(busy), 1);
        req = '0;
        @(negedge clk);
        cmp("op_gnt_low", 32'(gnt), 0);
        cmp("op_valid", 32'(res_valid), 1);
        cmp("op_sum", 32'(res_sum), 32'(xs));
        cmp("op_tag", 32'(res_tag), i);
        cmp("op_ovf", 32'(res_ovf), 32'(xo));
        @(negedge clk);
        cmp("op_idle", 32'(busy), 0);
        cmp("op_valid_low", 32'(res_valid), 0);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        cmp(nm, 32'(busy), 0);
    endtask

    localparam logic [15:0] OVF_SUM =
`ifdef ADDER_ARB_SAT_EN
        16'h7FFF;
`else
        16'h8000;
`endif

    initial begin
        int gq[$];
        int tq[$];
        rst_n     = 1'b0;
        req       = '0;
        a_bus     = '0;
        b_bus     = '0;
        sub_vec   = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        cmp("rst_gnt", 32'(gnt), 0);
        cmp("rst_valid", 32'(res_valid), 0);
        cmp("rst_busy", 32'(busy), 0);
        cmp("rst_sum", 32'(res_sum), 0);
        cmp("rst_tag", 32'(res_tag), 0);
        cmp("rst_ovf", 32'(res_ovf), 0);
        rst_n = 1'b1;

        do_op(0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0);
        do_op(1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0);
        do_op(2, 16'h7FFF, 16'h0001, 1'b0, OVF_SUM, 1'b1);
        do_op(3, 16'h0000, 16'h8000, 1'b1, OVF_SUM, 1'b1);

        scramble();
        req       = 4'b1111;
        res_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                gq.push_back($clog2(gnt));
                tq.push_back(c);
            end
        end
        req = '0;
        cmp("rr_count", gq.size(), 5);
        for (int k = 0; k < gq.size() && k < 5; k++) begin
            cmp("rr_order", gq[k], k % 4);
            cmp("rr_space", tq[k] - tq[0], 3 * k);
        end
        wait_idle("rr_idle");

        set_op(1, 16'h1234, 16'h0101, 1'b0);
        req       = 4'b0010;
        res_ready = 1'b0;
        @(negedge clk);
        cmp("hold_gnt", 32'(gnt), 32'h2);
        req = '0;
        scramble();
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            cmp("hold_valid", 32'(res_valid), 1);
            cmp("hold_sum", 32'(res_sum), 32'h1335);
            cmp("hold_tag", 32'(res_tag), 1);
            cmp("hold_gnt0", 32'(gnt), 0);
            cmp("hold_busy", 32'(busy), 1);
            req = 4'b1010;
            scramble();
            @(negedge clk);
        end
        req       = '0;
        res_ready = 1'b1;
        @(negedge clk);
        cmp("hold_done", 32'(res_valid), 0);
        cmp("hold_idle", 32'(busy), 0);

        do_op(2, 16'h0010, 16'h0020, 1'b1, 16'hFFF0, 1'b0);
        req       = 4'b1100;
        res_ready = 1'b0;
        @(negedge clk);
        cmp("r6_gnt3", 32'(gnt), 32'h8);
        @(negedge clk);
        cmp("r6_resp", 32'(res_valid), 1);
        rst_n = 1'b0;
        @(negedge clk);
        cmp("r6_valid", 32'(res_valid), 0);
        cmp("r6_busy", 32'(busy), 0);
        cmp("r6_gnt", 32'(gnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        cmp("r6_first", 32'(gnt), 32'h4);
        req       = '0;
        res_ready = 1'b1;
        wait_idle("r6_idle");

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req       = N'($urandom);
            scramble();
            res_ready = ($urandom % 4) != 0;
            rst_n     = ($urandom % 200) != 0;
        end
        @(negedge clk);
        rst_n     = 1'b1;
        req       = '0;
        res_ready = 1'b1;
        repeat (6) @(negedge clk);
        cmp("end_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
